// File: rtl/wb_spi_cmd_master.sv
// Wishbone classic single-cycle master that turns cmd/rsp handshakes into SPI core register accesses.
// Define WB_SPI_CMD_MASTER_TIMEOUT_EN to build in the bus-phase timeout counter.
module wb_spi_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [4:0]  cmd_adr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_int_i,
  output logic        irq_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        cmdReady_q, cmdReady_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [4:0]  adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        rspValid_q, rspValid_d;
  logic [31:0] rspRdata_q, rspRdata_d;
  logic        rspErr_q, rspErr_d;
  logic        irq_q;
  logic        busDone;

`ifdef WB_SPI_CMD_MASTER_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmoCnt_q, tmoCnt_d;
  logic       rspTimeout_q, rspTimeout_d;
`else
  // Without the counter the parameter only documents its legal range.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_unused
  end
`endif

  always_comb begin
    state_d    = state_q;
    cmdReady_d = cmdReady_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    rspValid_d = rspValid_q;
    rspRdata_d = rspRdata_q;
    rspErr_d   = rspErr_q;
    busDone    = 1'b0;
`ifdef WB_SPI_CMD_MASTER_TIMEOUT_EN
    tmoCnt_d     = tmoCnt_q;
    rspTimeout_d = rspTimeout_q;
`endif
    case (state_q)
      IDLE: begin
        cmdReady_d = 1'b1;
        if (cmd_valid && cmdReady_q) begin
          cmdReady_d = 1'b0;
          cyc_d      = 1'b1;
          we_d       = cmd_we;
          adr_d      = cmd_adr;
          dat_d      = cmd_wdata;
          sel_d      = cmd_sel;
          state_d    = BUS;
`ifdef WB_SPI_CMD_MASTER_TIMEOUT_EN
          tmoCnt_d   = 8'd0;
`endif
        end
      end
      BUS: begin
        if (wb_err_i) begin
          busDone    = 1'b1;
          rspErr_d   = 1'b1;
          rspRdata_d = 32'd0;
        end else if (wb_ack_i) begin
          busDone    = 1'b1;
          rspErr_d   = 1'b0;
          rspRdata_d = we_q ? 32'd0 : wb_dat_i;
        end
`ifdef WB_SPI_CMD_MASTER_TIMEOUT_EN
        else if (tmoCnt_q == TimeoutLast) begin
          busDone      = 1'b1;
          rspErr_d     = 1'b1;
          rspTimeout_d = 1'b1;
          rspRdata_d   = 32'd0;
        end else begin
          tmoCnt_d = tmoCnt_q + 8'd1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rspValid_d = 1'b0;
          rspRdata_d = 32'd0;
          rspErr_d   = 1'b0;
          cmdReady_d = 1'b1;
          state_d    = IDLE;
`ifdef WB_SPI_CMD_MASTER_TIMEOUT_EN
          rspTimeout_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Any bus termination parks the Wishbone outputs at zero and presents the response.
    if (busDone) begin
      cyc_d      = 1'b0;
      we_d       = 1'b0;
      adr_d      = 5'd0;
      dat_d      = 32'd0;
      sel_d      = 4'd0;
      rspValid_d = 1'b1;
      state_d    = RESP;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      cmdReady_q <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= 5'd0;
      dat_q      <= 32'd0;
      sel_q      <= 4'd0;
      rspValid_q <= 1'b0;
      rspRdata_q <= 32'd0;
      rspErr_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmdReady_q <= cmdReady_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      rspValid_q <= rspValid_d;
      rspRdata_q <= rspRdata_d;
      rspErr_q   <= rspErr_d;
      irq_q      <= wb_int_i;
    end
  end

`ifdef WB_SPI_CMD_MASTER_TIMEOUT_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tmoCnt_q     <= 8'd0;
      rspTimeout_q <= 1'b0;
    end else begin
      tmoCnt_q     <= tmoCnt_d;
      rspTimeout_q <= rspTimeout_d;
    end
  end

  assign rsp_timeout = rspTimeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready = cmdReady_q;
  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rspRdata_q;
  assign rsp_err   = rspErr_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign wb_we_o   = we_q;
  assign wb_stb_o  = cyc_q;
  assign wb_cyc_o  = cyc_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_spi_cmd_master.sv
// Directed scoreboard bench for wb_spi_cmd_master; follows WB_SPI_CMD_MASTER_TIMEOUT_EN like the RTL.
module tb_wb_spi_cmd_master;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [4:0]  cmd_adr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [4:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        wb_int_i = 1'b0;
  logic        irq_o;

  int checks = 0;
  int errors = 0;
  int cycles;
  rsp_t expQ[$];
  logic [4:0] curAdr;
  logic       curWe;

  wb_spi_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_int_i(wb_int_i), .irq_o(irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Hard stop in case a wait loop is ever left unbounded.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offers one command at a negedge, lets it be accepted, and checks the bus phase has started.
  task automatic applyStimulus(input logic we, input logic [4:0] adr, input logic [31:0] wdata,
                               input logic [3:0] sel, input logic [31:0] expRdata,
                               input logic expErr, input logic expTmo);
    rsp_t r;
    @(negedge wb_clk_i);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_wdata = wdata;
    cmd_sel   = sel;
    checkOutput("cmdReadyBefore", cmd_ready, 1);
    r.rdata = expRdata;
    r.err   = expErr;
    r.tmo   = expTmo;
    expQ.push_back(r);
    curAdr = adr;
    curWe  = we;
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    cmd_wdata = 32'h0;
    checkOutput("cmdReadyDrop", cmd_ready, 0);
    checkOutput("cycStart", wb_cyc_o, 1);
    checkOutput("stbStart", wb_stb_o, 1);
    checkOutput("busWe", wb_we_o, we);
    checkOutput("busDat", wb_dat_o, wdata);
    checkOutput("busSel", wb_sel_o, sel);
  endtask

  // Slave model: answers after the given wait states, or stays silent up to a cycle limit.
  task automatic runSlave(input int waits, input bit respond, input logic ack, input logic err,
                          input logic [31:0] data, input int limit, output int cnt);
    cnt = 0;
    while (wb_cyc_o === 1'b1 && cnt < limit) begin
      cnt++;
      checkOutput("busAdrHold", wb_adr_o, curAdr);
      checkOutput("busWeHold", wb_we_o, curWe);
      if (respond && cnt == waits + 1) begin
        wb_ack_i = ack;
        wb_err_i = err;
        wb_dat_i = data;
      end else begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'hFFFF_FFFF;
      end
      @(negedge wb_clk_i);
    end
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = 32'h0;
  endtask

  // Pops the scoreboard, optionally stalls rsp_ready while offering a command, then consumes.
  task automatic collectResponse(input int holdCycles);
    rsp_t r;
    int waitCnt = 0;
    while (rsp_valid !== 1'b1 && waitCnt < 50) begin
      waitCnt++;
      @(negedge wb_clk_i);
    end
    checkOutput("rspValidSeen", rsp_valid, 1);
    checkOutput("rspPending", expQ.size(), 1);
    if (expQ.size() == 0) return;
    r = expQ.pop_front();
    checkOutput("rspRdata", rsp_rdata, r.rdata);
    checkOutput("rspErr", rsp_err, r.err);
    checkOutput("rspTimeout", rsp_timeout, r.tmo);
    checkOutput("busIdleAdr", wb_adr_o, 0);
    checkOutput("busIdleWe", wb_we_o, 0);
    checkOutput("busIdleSel", wb_sel_o, 0);
    checkOutput("busIdleDat", wb_dat_o, 0);
    for (int i = 0; i < holdCycles; i++) begin
      cmd_valid = 1'b1;
      @(negedge wb_clk_i);
      checkOutput("holdValid", rsp_valid, 1);
      checkOutput("holdRdata", rsp_rdata, r.rdata);
      checkOutput("holdCmdReady", cmd_ready, 0);
      checkOutput("holdCyc", wb_cyc_o, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
    checkOutput("rspCleared", rsp_valid, 0);
    checkOutput("rspRdataCleared", rsp_rdata, 0);
    checkOutput("rspErrCleared", rsp_err, 0);
    checkOutput("cmdReadyAgain", cmd_ready, 1);
  endtask

  initial begin
    // Reset state, with interrupt and bus inputs active to prove they are masked.
    wb_int_i = 1'b1;
    #12;
    checkOutput("rstCmdReady", cmd_ready, 0);
    checkOutput("rstCyc", wb_cyc_o, 0);
    checkOutput("rstRspValid", rsp_valid, 0);
    checkOutput("rstIrq", irq_o, 0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    wb_int_i = 1'b0;
    #1;
    checkOutput("relCmdReadyLow", cmd_ready, 0);
    @(posedge wb_clk_i);
    #1;
    checkOutput("relCmdReadyHigh", cmd_ready, 1);

    // Interrupt pass-through is a one-clock delay.
    @(negedge wb_clk_i);
    wb_int_i = 1'b1;
    #1;
    checkOutput("irqNotYet", irq_o, 0);
    @(posedge wb_clk_i);
    #1;
    checkOutput("irqRise", irq_o, 1);
    @(negedge wb_clk_i);
    wb_int_i = 1'b0;
    @(posedge wb_clk_i);
    #1;
    checkOutput("irqFall", irq_o, 0);

    // Stray ack/err while idle must do nothing.
    @(negedge wb_clk_i);
    wb_ack_i = 1'b1;
    wb_err_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    checkOutput("strayRspValid", rsp_valid, 0);
    checkOutput("strayCyc", wb_cyc_o, 0);
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;

    // Write with ack on the first bus cycle; read data from slave must not leak.
    applyStimulus(1'b1, 5'h10, 32'h0000_0A5A, 4'hF, 32'h0, 1'b0, 1'b0);
    runSlave(0, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 40, cycles);
    checkOutput("writeCycles", cycles, 1);
    collectResponse(0);

    // Read with three wait states, response held off for ten cycles.
    applyStimulus(1'b0, 5'h00, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0);
    runSlave(3, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 40, cycles);
    checkOutput("readCycles", cycles, 4);
    collectResponse(10);

    // Ack and err on the same edge: err wins and data is dropped.
    applyStimulus(1'b0, 5'h04, 32'h0, 4'h3, 32'h0, 1'b1, 1'b0);
    runSlave(1, 1'b1, 1'b1, 1'b1, 32'h5555_AAAA, 40, cycles);
    checkOutput("ackErrCycles", cycles, 2);
    collectResponse(0);

    // Partial-select read with two wait states.
    applyStimulus(1'b0, 5'h1F, 32'h0, 4'h6, 32'h0BAD_F00D, 1'b0, 1'b0);
    runSlave(2, 1'b1, 1'b1, 1'b0, 32'h0BAD_F00D, 40, cycles);
    checkOutput("partialCycles", cycles, 3);
    collectResponse(0);

`ifdef WB_SPI_CMD_MASTER_TIMEOUT_EN
    // Silent slave: abort after sixteen bus cycles.
    applyStimulus(1'b0, 5'h08, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1);
    runSlave(0, 1'b0, 1'b0, 1'b0, 32'h0, 40, cycles);
    checkOutput("timeoutCycles", cycles, 16);
    collectResponse(0);
    applyStimulus(1'b1, 5'h0C, 32'hCAFE_0001, 4'hF, 32'h0, 1'b0, 1'b0);
    runSlave(0, 1'b0, 1'b0, 1'b0, 32'h0, 5, cycles);
    checkOutput("silentCycles", cycles, 5);
`else
    // Silent slave without timeout: the cycle never ends on its own.
    applyStimulus(1'b1, 5'h0C, 32'hCAFE_0001, 4'hF, 32'h0, 1'b0, 1'b0);
    runSlave(0, 1'b0, 1'b0, 1'b0, 32'h0, 120, cycles);
    checkOutput("silentCycles", cycles, 120);
    checkOutput("silentRspTimeout", rsp_timeout, 0);
`endif

    // Reset mid-bus discards the command entirely.
    checkOutput("preRstCyc", wb_cyc_o, 1);
    wb_rst_i = 1'b1;
    #1;
    checkOutput("midRstCyc", wb_cyc_o, 0);
    checkOutput("midRstStb", wb_stb_o, 0);
    checkOutput("midRstRspValid", rsp_valid, 0);
    checkOutput("midRstCmdReady", cmd_ready, 0);
    expQ.delete();
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    #1;
    checkOutput("midRelCmdReadyLow", cmd_ready, 0);
    @(posedge wb_clk_i);
    #1;
    checkOutput("midRelCmdReadyHigh", cmd_ready, 1);
    repeat (3) @(negedge wb_clk_i);
    checkOutput("postRstRspValid", rsp_valid, 0);
    checkOutput("postRstCyc", wb_cyc_o, 0);

    // Normal traffic resumes after the reset.
    applyStimulus(1'b0, 5'h02, 32'h0, 4'hF, 32'h0000_00C3, 1'b0, 1'b0);
    runSlave(0, 1'b1, 1'b1, 1'b0, 32'h0000_00C3, 40, cycles);
    checkOutput("resumeCycles", cycles, 1);
    collectResponse(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
